// File: rtl/iir_output_decimator_if.sv
// Handshake/data bundle for iir_output_decimator.
//   master : upstream/consumer side (drives samples, r_log2, out_ready, clr_ovf)
//   slave  : the decimator (drives avg_out, out_valid, fifo_count, overflow)
interface iir_output_decimator_if #(
    parameter int N     = 16,
    parameter int DEPTH = 4
);
    logic signed [N-1:0]            y_in;
    logic                           in_valid;
    logic [2:0]                     r_log2;
    logic signed [N-1:0]            avg_out;
    logic                           out_valid;
    logic                           out_ready;
    logic [$clog2(DEPTH):0]         fifo_count;
    logic                           overflow;
    logic                           clr_ovf;

    modport master (
        output y_in, in_valid, r_log2, out_ready, clr_ovf,
        input  avg_out, out_valid, fifo_count, overflow
    );
    modport slave (
        input  y_in, in_valid, r_log2, out_ready, clr_ovf,
        output avg_out, out_valid, fifo_count, overflow
    );
endinterface

// File: rtl/iir_output_decimator.sv
// Averages groups of 2^r_eff valid samples (r_eff = min(r_log2, RMAX)) and
// queues each result in a small output FIFO.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : slave modport carrying y_in/in_valid/r_log2 (input side),
//                avg_out/out_valid/out_ready/fifo_count (output side),
//                overflow/clr_ovf (sticky drop flag and its clear)
module iir_output_decimator #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int RMAX  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    iir_output_decimator_if.slave bus
);
    localparam int AW  = N + RMAX;       // wide enough for 2^RMAX N-bit samples
    localparam int PHW = RMAX + 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    logic signed [AW-1:0] r_acc;
    logic [PHW-1:0]       r_phase;
    logic [2:0]           r_reff;
    logic [N-1:0]         r_mem [DEPTH];
    logic [PW-1:0]        r_wp, r_rp;
    logic [CW-1:0]        r_cnt;
    logic                 r_ovf;

    logic [2:0]           w_reff_in, w_reff;
    logic [PHW-1:0]       w_last_ph;
    logic                 w_last;
    logic signed [AW-1:0] w_sum, w_shift;
    logic [N-1:0]         w_res;
    logic                 w_push, w_pop, w_full, w_wr, w_drop;

    assign w_reff_in = (int'(bus.r_log2) > RMAX) ? 3'(RMAX) : bus.r_log2;
    // The group's factor is taken live on its first sample, then held.
    assign w_reff    = (r_phase == '0) ? w_reff_in : r_reff;
    assign w_last_ph = (PHW'(1) << w_reff) - PHW'(1);
    assign w_last    = (r_phase == w_last_ph);

    assign w_sum   = r_acc + {{RMAX{bus.y_in[N-1]}}, bus.y_in};
    // Arithmetic shift floors toward -inf; the mean of N-bit values fits N bits.
    assign w_shift = w_sum >>> w_reff;
    assign w_res   = w_shift[N-1:0];

    assign w_push = bus.in_valid && w_last;
    assign w_pop  = (r_cnt != '0) && bus.out_ready;
    assign w_full = (r_cnt == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_phase <= '0;
            r_reff  <= '0;
        end else if (bus.in_valid) begin
            r_reff <= w_reff;
            if (w_last) begin
                r_acc   <= '0;
                r_phase <= '0;
            end else begin
                r_acc   <= w_sum;
                r_phase <= r_phase + PHW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr)  r_wp <= r_wp + PW'(1);
            if (w_pop) r_rp <= r_rp + PW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_drop)           r_ovf <= 1'b1;
            else if (bus.clr_ovf) r_ovf <= 1'b0;
        end
    end

    // Storage needs no reset: it is only visible while r_cnt is non-zero.
    always_ff @(posedge clk) begin
        if (!rst && w_wr) r_mem[r_wp] <= w_res;
    end

    assign bus.out_valid  = (r_cnt != '0);
    assign bus.avg_out    = bus.out_valid ? r_mem[r_rp] : '0;
    assign bus.fifo_count = r_cnt;
    assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_iir_output_decimator.sv
module tb_iir_output_decimator;
    localparam int N     = 16;
    localparam int DEPTH = 4;
    localparam int RMAX  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iir_output_decimator_if #(.N(N), .DEPTH(DEPTH)) bus ();

    iir_output_decimator #(.N(N), .DEPTH(DEPTH), .RMAX(RMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    longint sbq[$];       // expected results in delivery order
    int     mcnt  = 0;    // results stored
    bit     movf  = 0;
    int     mph   = 0;    // samples in current group
    int     mr    = 0;    // group's log2 factor
    longint msum  = 0;

    function automatic longint floordiv(longint a, longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0d expected none at %0t", bus.avg_out, $time);
            end else begin
                longint e;
                e = sbq.pop_front();
                if (longint'(bus.avg_out) != e) begin
                    errors++;
                    $display("FAIL avg_out: got %0d expected %0d at %0t", bus.avg_out, e, $time);
                end
            end
        end
    end

    // One clock cycle: check state visible now, drive inputs, advance model, clock.
    task automatic step(bit vld, int y, int rl, bit rdy, bit clr);
        bit pop, push, drop;
        longint res;
        chk("fifo_count", longint'(bus.fifo_count), mcnt);
        chk("out_valid", longint'(bus.out_valid), longint'(mcnt != 0));
        chk("overflow", longint'(bus.overflow), longint'(movf));
        bus.in_valid  = vld;
        bus.y_in      = N'(y);
        bus.r_log2    = 3'(rl);
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
        pop  = (mcnt > 0) && rdy;
        push = 0;
        res  = 0;
        if (vld) begin
            if (mph == 0) mr = (rl > RMAX) ? RMAX : rl;
            msum += longint'($signed(N'(y)));
            mph++;
            if (mph == (1 << mr)) begin
                res  = floordiv(msum, longint'(1) << mr);
                push = 1;
                mph  = 0;
                msum = 0;
            end
        end
        drop = push && (mcnt == DEPTH) && !pop;
        if (push && !drop) sbq.push_back(res);
        mcnt = mcnt + ((push && !drop) ? 1 : 0) - (pop ? 1 : 0);
        if (drop)     movf = 1;
        else if (clr) movf = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        bus.y_in      = '0;
        bus.r_log2    = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        mcnt = 0; movf = 0; mph = 0; mr = 0; msum = 0;
        chk("rst_count", longint'(bus.fifo_count), 0);
        chk("rst_valid", longint'(bus.out_valid), 0);
        chk("rst_avg", longint'(bus.avg_out), 0);
        chk("rst_ovf", longint'(bus.overflow), 0);
    endtask

    task automatic idle(int n, bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0);
    endtask

    initial begin
        int s[4];
        do_reset();
        @(posedge clk); #1;
        do_reset();

        // Mean of 100..400 is 250, one result, out_valid for one cycle.
        s = '{100, 200, 300, 400};
        foreach (s[i]) step(1, s[i], 2, 1, 0);
        chk("q_before_250", sbq.size(), 1);
        idle(3, 1);

        // Floor toward -inf and r_log2 clamp to RMAX.
        step(1, -3, 1, 1, 0);
        step(1, -2, 1, 1, 0);
        idle(2, 1);
        for (int i = 0; i < 16; i++) step(1, 5, 7, 1, 0);
        idle(2, 1);

        // Pass-through, overfill with consumer stalled, then drain.
        for (int i = 1; i <= 6; i++) step(1, i, 0, 0, 0);
        chk("ovf_set", longint'(bus.overflow), 1);
        idle(6, 1);
        step(0, 0, 0, 0, 1);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 4; i++) step(1, 10 + i, 0, 0, 0);
        step(1, 99, 0, 1, 0);
        chk("full_keep", longint'(bus.fifo_count), 4);
        idle(6, 1);

        // One stored, push+pop same cycle.
        step(1, 31, 0, 0, 0);
        step(1, 32, 0, 1, 0);
        idle(3, 1);

        // Reset mid-group discards the partial sum.
        step(1, 10, 2, 1, 0);
        step(1, 20, 2, 1, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 4, 2, 1, 0);
        idle(3, 1);

        // Gappy input; r_log2 change mid-group is ignored.
        step(1, 7, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        step(1, 9, 3, 1, 0);
        idle(3, 1);

        // Drop coinciding with clr_ovf keeps overflow set.
        for (int i = 0; i < 4; i++) step(1, i, 0, 0, 0);
        step(1, 77, 0, 0, 1);
        chk("ovf_drop_wins", longint'(bus.overflow), 1);
        step(0, 0, 0, 0, 1);
        chk("ovf_cleared", longint'(bus.overflow), 0);
        idle(6, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, int'($urandom % 65536) - 32768,
                 int'($urandom % 8), ($urandom % 3) != 0, ($urandom % 16) == 0);
        idle(DEPTH + 3, 1);
        chk("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/iir_output_decimator.md
IIR_OUTPUT_DECIMATOR -- requirements
Module: iir_output_decimator

Interface
REQ-001 Parameter N, default 16, sample width of input and output.
REQ-002 Parameter DEPTH, default 4, output FIFO depth in results; power of two, >= 2.
REQ-003 Parameter RMAX, default 4, largest allowed log2 decimation factor.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 y_in  input  N  signed sample from the upstream IIR stage output.
REQ-007 in_valid  input  1  y_in holds a new sample this cycle.
REQ-008 r_log2  input  3  log2 of the decimation factor R.
REQ-009 avg_out  output  N  signed decimated result at the FIFO head.
REQ-010 out_valid  output  1  avg_out is valid.
REQ-011 out_ready  input  1  consumer accepts avg_out this cycle.
REQ-012 fifo_count  output  clog2(DEPTH)+1  number of results stored.
REQ-013 overflow  output  1  sticky flag: a result was dropped.
REQ-014 clr_ovf  input  1  clears overflow.

Function
REQ-015 Block shall average each group of R = 2^r_eff consecutive valid samples, with r_eff = min(r_log2, RMAX).
REQ-016 r_eff shall be latched on the first valid sample of a group (phase == 0); r_log2 changes mid-group shall not affect that group.
REQ-017 Accumulator shall be signed, N+RMAX bits wide, and shall never overflow.
REQ-018 Phase counter shall advance only on in_valid; cycles without in_valid shall leave the accumulator and phase unchanged.
REQ-019 On the R-th valid sample, result = (acc + y_in) >>> r_eff (arithmetic shift, floor toward -inf), truncated to N bits (always in range); acc and phase shall return to 0 that cycle.
REQ-020 R = 1 (r_eff = 0) shall pass every valid sample through unchanged.
REQ-021 Result shall be pushed into the FIFO at the clock edge of the completing sample; out_valid shall rise the following cycle when the FIFO was empty (latency 1 cycle).
REQ-022 out_valid = (fifo_count != 0); a pop occurs when out_valid && out_ready.
REQ-023 While out_valid && !out_ready, avg_out shall hold stable.
REQ-024 Push while full without a pop in the same cycle shall drop the new result and set overflow; FIFO contents shall be unchanged.
REQ-025 Push and pop in the same cycle while full shall both occur, fifo_count shall stay DEPTH, and overflow shall not be set.
REQ-026 Push and pop in the same cycle while one result is stored: new result becomes head, fifo_count stays 1.
REQ-027 Read and write pointers shall wrap modulo DEPTH.
REQ-028 clr_ovf shall clear overflow; a drop in the same cycle as clr_ovf shall win (overflow = 1).

Reset
REQ-029 While rst is high at a clock edge: acc = 0, phase = 0, FIFO emptied, fifo_count = 0, out_valid = 0, avg_out = 0, overflow = 0, latched r_eff = 0.
REQ-030 Reset asserted mid-group shall discard the partial sum; the first valid sample after reset starts a new group.
REQ-031 rst shall take priority over in_valid, out_ready and clr_ovf.

Verification
REQ-032 r_log2=2, in_valid=1 with samples 100,200,300,400, out_ready=1 -> one result 250, out_valid high exactly 1 cycle, starting the cycle after the 400 is sampled.
REQ-033 r_log2=1, samples -3,-2 -> avg_out = -3 (floor of -2.5); r_log2=7 with 16 samples of 5 -> r_eff=4, result 5.
REQ-034 r_log2=0, out_ready=0, 6 samples 1..6 with DEPTH=4 -> fifo_count=4, overflow=1, pops then return 1,2,3,4.
REQ-035 FIFO full, simultaneous push and pop -> fifo_count stays 4, overflow stays 0, next pops in push order.
REQ-036 r_log2=2, samples 10,20 then rst pulse, then 4,4,4,4 -> single result 4; the earlier partial sum never appears.
REQ-037 in_valid toggled every other cycle, r_log2=1, samples 7,9 -> result 8; clr_ovf coinciding with a drop -> overflow remains 1.
